opnd_fetch: RTL and testbench
=============================

// Module: opnd_fetch
// PURPOSE
//  Operand reader for the execute stage: reads up to two x86 operands through one RF read port
//   and delivers them as opnd0_r/opnd1_r to execute units (move/swap etc.).
//  Mirror of the operand write path: executes consume opnd*_r and produce opnd*_w.
//  Fixed-latency FSM with valid/ready on both request and response sides.
// PARAMETERS
//  REG_COUNT  8   number of architectural GPRs (EAX..EDI)
//  IDX_W      3   register index width, = clog2(REG_COUNT)
//  DATA_W     32  register/operand width
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       operand request valid
//  req_ready    out  1       request accepted when req_valid & req_ready
//  opnd0_sel    in   IDX_W+3 [IDX_W-1:0] reg idx, [IDX_W+1:IDX_W] size, [IDX_W+2] use_imm
//  opnd1_sel    in   IDX_W+3 same encoding as opnd0_sel
//  imm          in   DATA_W  immediate value, shared by both operands
//  rf_rd_en     out  1       RF read strobe
//  rf_rd_idx    out  IDX_W   RF read index
//  rf_rd_data   in   DATA_W  RF read data, valid exactly 1 cycle after rf_rd_en
//  wb_valid     in   1       same-cycle RF write (bypass source, see CONFIGURATION)
//  wb_idx       in   IDX_W   RF write index
//  wb_data      in   DATA_W  RF write data
//  rsp_valid    out  1       operands valid
//  rsp_ready    in   1       consumer accepts when rsp_valid & rsp_ready
//  opnd0_r      out  DATA_W  operand 0, zero-extended
//  opnd1_r      out  DATA_W  operand 1, zero-extended
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; req_ready=1 after reset; rsp_valid=0, rf_rd_en=0,
//   rf_rd_idx=0, opnd0_r=opnd1_r=0; captured sel/imm cleared.
//  States: IDLE -> RD0 -> RD1 -> CAP -> RSP -> IDLE.
//   IDLE: req_ready=1; on req_valid latch opnd0_sel, opnd1_sel, imm; -> RD0. No other state asserts req_ready.
//   RD0:  rf_rd_en=~use_imm0, rf_rd_idx=idx0; -> RD1.
//   RD1:  opnd0_r <= extract(use_imm0 ? imm : rd_src(idx0)); rf_rd_en=~use_imm1, rf_rd_idx=idx1; -> CAP.
//   CAP:  opnd1_r <= extract(use_imm1 ? imm : rd_src(idx1)); -> RSP.
//   RSP:  rsp_valid=1; opnd*_r stable until rsp_ready; on rsp_ready -> IDLE (req_ready=1 next cycle).
//  Latency: request accepted at edge T -> rsp_valid high from T+4 regardless of imm/reg mix.
//  Throughput: one request per 5 cycles minimum; no overlap, no queueing.
//  rf_rd_idx held at 0 whenever rf_rd_en=0.
//  extract(size): 00 -> {24'b0,d[7:0]}; 01 -> {24'b0,d[15:8]} (AH/CH/DH/BH);
//   10 -> {16'b0,d[15:0]}; 11 -> d[31:0]. Applied to immediates too.
//  Same register in both operands: read twice, no sharing; both results independently extracted.
//  rsp_ready high while rsp_valid low: ignored. req_valid outside IDLE: ignored (not latched).
//  Reset mid-operation: transaction dropped, no rsp_valid produced, state IDLE.
// CONFIGURATION
//  OPND_FETCH_BYPASS_EN defined: rd_src(i) = (wb_valid && wb_idx==i) ? wb_data : rf_rd_data,
//   evaluated in the capture cycle (RD1 for opnd0, CAP for opnd1); full 32-bit wb_data before extract.
//  Undefined: rd_src(i) = rf_rd_data; wb_valid/wb_idx/wb_data ports present but ignored.
// TESTING
//  Reset: rst_n=0 mid-RD1 -> next cycle state IDLE, rsp_valid=0, opnd0_r=0, rf_rd_en=0.
//  Reg/reg dword: EAX=0x11223344, ECX=0xAABBCCDD, sel0=EAX/11, sel1=ECX/11 -> rsp_valid at T+4,
//   opnd0_r=0x11223344, opnd1_r=0xAABBCCDD; rf_rd_en pulses at T+1 (idx0) and T+2 (idx1).
//  Sub-register: EBX=0x0000BEEF, sel0=idx3/01, sel1=idx3/00 -> opnd0_r=0x000000BE, opnd1_r=0x000000EF.
//  Immediate: sel1 use_imm=1 size=10, imm=0x12345678 -> opnd1_r=0x00005678; no rf_rd_en in RD1.
//  Backpressure: rsp_ready=0 for 3 cycles -> rsp_valid and operands held stable, req_ready=0; release -> IDLE.
//  Bypass (macro set): RF EDX=0x1, wb_valid=1 wb_idx=2 wb_data=0x5 in RD1, sel0=EDX/11 -> opnd0_r=0x5;
//   macro unset -> opnd0_r=0x1.

Source files
------------

// File: rtl/opnd_fetch.sv
// rtl/opnd_fetch.sv - two-operand register-file reader feeding the execute stage
// Optional write-back bypass on the read data is enabled by defining OPND_FETCH_BYPASS_EN.
module opnd_fetch #(
   parameter int REG_COUNT = 8,
   parameter int IDX_W     = 3,
   parameter int DATA_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [IDX_W+2:0]    opnd0_sel,
   input  logic [IDX_W+2:0]    opnd1_sel,
   input  logic [DATA_W-1:0]   imm,
   output logic                rf_rd_en,
   output logic [IDX_W-1:0]    rf_rd_idx,
   input  logic [DATA_W-1:0]   rf_rd_data,
   input  logic                wb_valid,
   input  logic [IDX_W-1:0]    wb_idx,
   input  logic [DATA_W-1:0]   wb_data,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   opnd0_r,
   output logic [DATA_W-1:0]   opnd1_r
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD0  = 3'd1,
      S_RD1  = 3'd2,
      S_CAP  = 3'd3,
      S_RSP  = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [IDX_W+2:0]  sel0_q, sel1_q;
   logic [DATA_W-1:0] imm_q;

   logic [IDX_W-1:0]  idx0, idx1;
   logic [1:0]        size0, size1;
   logic              use_imm0, use_imm1;
   logic [DATA_W-1:0] src0, src1;
   logic              unused_cfg;

   assign idx0     = sel0_q[IDX_W-1:0];
   assign size0    = sel0_q[IDX_W+1:IDX_W];
   assign use_imm0 = sel0_q[IDX_W+2];
   assign idx1     = sel1_q[IDX_W-1:0];
   assign size1    = sel1_q[IDX_W+1:IDX_W];
   assign use_imm1 = sel1_q[IDX_W+2];

   // Size 01 selects the high byte of the low word (AH/CH/DH/BH).
   function automatic logic [DATA_W-1:0] extract(input logic [1:0] size,
                                                 input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      r = '0;
      case (size)
         2'b00:   r[7:0]  = d[7:0];
         2'b01:   r[7:0]  = d[15:8];
         2'b10:   r[15:0] = d[15:0];
         default: r       = d;
      endcase
      return r;
   endfunction

`ifdef OPND_FETCH_BYPASS_EN
   // A write landing in the capture cycle is newer than what the RF returned.
   assign src0 = (wb_valid && (wb_idx == idx0)) ? wb_data : rf_rd_data;
   assign src1 = (wb_valid && (wb_idx == idx1)) ? wb_data : rf_rd_data;
   assign unused_cfg = (REG_COUNT > (1 << IDX_W));
`else
   assign src0 = rf_rd_data;
   assign src1 = rf_rd_data;
   assign unused_cfg = (REG_COUNT > (1 << IDX_W)) ^ wb_valid ^ (^wb_idx) ^ (^wb_data);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rf_rd_en  = 1'b0;
      rf_rd_idx = '0;
      rsp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nx = S_RD0;
            end
         end
         S_RD0: begin
            rf_rd_en = ~use_imm0;
            if (!use_imm0) begin
               rf_rd_idx = idx0;
            end
            state_nx = S_RD1;
         end
         S_RD1: begin
            rf_rd_en = ~use_imm1;
            if (!use_imm1) begin
               rf_rd_idx = idx1;
            end
            state_nx = S_CAP;
         end
         S_CAP: begin
            state_nx = S_RSP;
         end
         S_RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel0_q  <= '0;
         sel1_q  <= '0;
         imm_q   <= '0;
         opnd0_r <= '0;
         opnd1_r <= '0;
      end else begin
         if ((state == S_IDLE) && req_valid) begin
            sel0_q <= opnd0_sel;
            sel1_q <= opnd1_sel;
            imm_q  <= imm;
         end
         if (state == S_RD1) begin
            opnd0_r <= extract(size0, use_imm0 ? imm_q : src0);
         end
         if (state == S_CAP) begin
            opnd1_r <= extract(size1, use_imm1 ? imm_q : src1);
         end
      end
   end

endmodule

// File: tb/tb_opnd_fetch.sv
// tb/tb_opnd_fetch.sv - directed and randomized checks of opnd_fetch against a reference model
// Models a registered-read RF; build with OPND_FETCH_BYPASS_EN to check the bypass variant.
module tb_opnd_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  opnd0_sel;
   logic [5:0]  opnd1_sel;
   logic [31:0] imm;
   logic        rf_rd_en;
   logic [2:0]  rf_rd_idx;
   logic [31:0] rf_rd_data;
   logic        wb_valid;
   logic [2:0]  wb_idx;
   logic [31:0] wb_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] opnd0_r;
   logic [31:0] opnd1_r;

   int checks = 0;
   int errors = 0;

`ifdef OPND_FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic [31:0] rf [8];

   opnd_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .opnd0_sel  (opnd0_sel),
      .opnd1_sel  (opnd1_sel),
      .imm        (imm),
      .rf_rd_en   (rf_rd_en),
      .rf_rd_idx  (rf_rd_idx),
      .rf_rd_data (rf_rd_data),
      .wb_valid   (wb_valid),
      .wb_idx     (wb_idx),
      .wb_data    (wb_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .opnd0_r    (opnd0_r),
      .opnd1_r    (opnd1_r)
   );

   always #5 clk = ~clk;

   // Data is only meaningful the cycle after a strobe; garbage otherwise.
   always @(posedge clk) begin
      if (rf_rd_en) rf_rd_data <= rf[rf_rd_idx];
      else          rf_rd_data <= $urandom;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ext(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'd0:    return d & 32'h0000_00ff;
         2'd1:    return (d >> 8) & 32'h0000_00ff;
         2'd2:    return d & 32'h0000_ffff;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] model(input logic [5:0] sel, input logic [31:0] immv,
                                         input logic wv, input logic [2:0] wi,
                                         input logic [31:0] wd);
      logic [31:0] src;
      if (sel[5]) src = immv;
      else if (BYP && wv && (wi == sel[2:0])) src = wd;
      else src = rf[sel[2:0]];
      return ext(sel[4:3], src);
   endfunction

   // Called at #1 after a rising edge with the DUT idle.
   task automatic txn(input logic [5:0] s0, input logic [5:0] s1, input logic [31:0] im,
                      input logic w0v, input logic [2:0] w0i, input logic [31:0] w0d,
                      input logic w1v, input logic [2:0] w1i, input logic [31:0] w1d,
                      input int hold);
      logic [31:0] exp0, exp1;
      exp0 = model(s0, im, w0v, w0i, w0d);
      exp1 = model(s1, im, w1v, w1i, w1d);
      chk("idle_req_ready", req_ready, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      req_valid = 1'b1; opnd0_sel = s0; opnd1_sel = s1; imm = im;
      rsp_ready = 1'($urandom);
      @(posedge clk); #1;
      opnd0_sel = 6'($urandom); opnd1_sel = 6'($urandom); imm = $urandom;
      rsp_ready = 1'($urandom);
      chk("rd0_rf_rd_en", rf_rd_en, !s0[5]);
      chk("rd0_rf_rd_idx", rf_rd_idx, s0[5] ? 3'd0 : s0[2:0]);
      chk("rd0_req_ready", req_ready, 0);
      chk("rd0_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      wb_valid = w0v; wb_idx = w0i; wb_data = w0d;
      rsp_ready = 1'($urandom);
      chk("rd1_rf_rd_en", rf_rd_en, !s1[5]);
      chk("rd1_rf_rd_idx", rf_rd_idx, s1[5] ? 3'd0 : s1[2:0]);
      chk("rd1_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      wb_valid = w1v; wb_idx = w1i; wb_data = w1d;
      rsp_ready = 1'($urandom);
      chk("cap_opnd0", opnd0_r, exp0);
      chk("cap_rf_rd_en", rf_rd_en, 0);
      chk("cap_rf_rd_idx", rf_rd_idx, 0);
      chk("cap_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      wb_valid = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_opnd0", opnd0_r, exp0);
      chk("rsp_opnd1", opnd1_r, exp1);
      chk("rsp_req_ready", req_ready, 0);
      for (int i = 0; i < hold; i++) begin
         wb_valid = 1'($urandom); wb_idx = 3'($urandom); wb_data = $urandom;
         @(posedge clk); #1;
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_opnd0", opnd0_r, exp0);
         chk("hold_opnd1", opnd1_r, exp1);
         chk("hold_req_ready", req_ready, 0);
      end
      wb_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_req_ready", req_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      opnd0_sel = '0; opnd1_sel = '0; imm = '0;
      wb_valid = 1'b0; wb_idx = '0; wb_data = '0;
      for (int i = 0; i < 8; i++) rf[i] = $urandom;
      rf[0] = 32'h1122_3344;
      rf[1] = 32'hAABB_CCDD;
      rf[2] = 32'h0000_0001;
      rf[3] = 32'h0000_BEEF;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rf_rd_en", rf_rd_en, 0);
      chk("rst_rf_rd_idx", rf_rd_idx, 0);
      chk("rst_opnd0", opnd0_r, 0);
      chk("rst_opnd1", opnd1_r, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // reg/reg dword, sub-register, immediate, backpressure, bypass, same register twice
      txn({1'b0, 2'b11, 3'd0}, {1'b0, 2'b11, 3'd1}, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      txn({1'b0, 2'b01, 3'd3}, {1'b0, 2'b00, 3'd3}, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      txn({1'b0, 2'b11, 3'd0}, {1'b1, 2'b10, 3'd5}, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
      txn({1'b1, 2'b01, 3'd7}, {1'b0, 2'b10, 3'd1}, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 3);
      txn({1'b0, 2'b11, 3'd2}, {1'b0, 2'b11, 3'd1}, 32'h0, 1, 3'd2, 32'h5, 0, 0, 0, 0);
      txn({1'b0, 2'b11, 3'd1}, {1'b0, 2'b11, 3'd2}, 32'h0, 1, 3'd4, 32'h77, 1, 3'd2, 32'h9, 1);
      txn({1'b0, 2'b00, 3'd1}, {1'b0, 2'b01, 3'd1}, 32'h0, 0, 0, 0, 0, 0, 0, 0);

      // reset while in RD1 drops the transaction
      chk("pre_rst_opnd0_nonzero", (opnd0_r != 0), 1);
      req_valid = 1'b1; opnd0_sel = {1'b0, 2'b11, 3'd0}; opnd1_sel = {1'b0, 2'b11, 3'd1};
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_rd1_rf_rd_en", rf_rd_en, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_opnd0", opnd0_r, 0);
      chk("mid_rst_rf_rd_en", rf_rd_en, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("post_rst_rsp_valid", rsp_valid, 0);
         chk("post_rst_req_ready", req_ready, 1);
      end

      for (int n = 0; n < 60; n++) begin
         txn(6'($urandom), 6'($urandom), $urandom,
             1'($urandom), 3'($urandom), $urandom,
             1'($urandom), 3'($urandom), $urandom,
             int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
